// File: rtl/branch_pc_seq_pkg.sv
// Shared constants for the branch PC sequencer: FSM state encoding and
// instruction-register field positions used by the branch datapath.
package branch_pc_seq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STROBE = 2'd1,
    EVAL   = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int C_FIELD_W = 19;
  localparam int C_LSB     = 0;
  localparam int C_MSB     = 18;

  // C2 selects the condition and belongs to the CON flip-flop, not this block
  localparam int C2_LSB = 19;
  localparam int C2_MSB = 20;

endpackage

// File: rtl/branch_pc_seq_sext_imm.sv
// Combinational sign extender from the IMM_W-bit branch displacement to PC_W.
module sext_imm #(
  parameter int IMM_W = 19,
  parameter int PC_W  = 32
) (
  input  logic [IMM_W-1:0] imm,
  output logic [PC_W-1:0]  ext
);

  assign ext = {{(PC_W-IMM_W){imm[IMM_W-1]}}, imm};

endmodule

// File: rtl/branch_pc_seq.sv
// Program-counter sequencer: fetch increment, direct loads, and a
// three-cycle conditional branch that strobes and then samples the CON flip-flop.
module branch_pc_seq
  import branch_pc_seq_pkg::*;
#(
  parameter int              PC_W     = 32,
  parameter int              IMM_W    = C_FIELD_W,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            clr,
  input  logic            inc,
  input  logic            load,
  input  logic [PC_W-1:0] load_val,
  input  logic            br_start,
  input  logic [31:0]     ir,
  input  logic            con,
  output logic [PC_W-1:0] pc,
  output logic            con_in,
  output logic            busy,
  output logic            br_done,
  output logic            br_taken
);

  state_t          state, next_state;
  logic [PC_W-1:0] off;
  logic [PC_W-1:0] off_ext;
  logic            taken;
  logic            unused_ir_bits;

  assign unused_ir_bits = ^ir[31:IMM_W];

  sext_imm #(.IMM_W(IMM_W), .PC_W(PC_W)) u_sext (
    .imm (ir[IMM_W-1:0]),
    .ext (off_ext)
  );

  always_ff @(posedge clk or posedge clr) begin
    if (clr) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    con_in     = 1'b0;
    busy       = 1'b1;
    br_done    = 1'b0;
    br_taken   = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (br_start) next_state = STROBE;
      end
      STROBE: begin
        con_in     = 1'b1;
        next_state = EVAL;
      end
      EVAL: next_state = DONE;
      DONE: begin
        br_done    = 1'b1;
        br_taken   = taken;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Requests arriving outside IDLE are dropped; a branch beats load beats inc
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      pc    <= RESET_PC;
      off   <= '0;
      taken <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (br_start)  off <= off_ext;
          else if (load) pc  <= load_val;
          else if (inc)  pc  <= pc + PC_W'(1);
        end
        EVAL: begin
          if (con) pc <= pc + off;
          taken <= con;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_branch_pc_seq.sv
// Self-checking bench for branch_pc_seq: directed reset/increment checks,
// a table of branch vectors, arbitration cases and randomized traffic vs a model.
module tb_branch_pc_seq;

  logic        clk = 1'b0;
  logic        clr;
  logic        inc, load, br_start, con;
  logic [31:0] load_val, ir;
  logic [31:0] pc;
  logic        con_in, busy, br_done, br_taken;

  int total = 0;
  int bad   = 0;
  logic [31:0] m_pc;

  typedef struct {
    logic [31:0] start_pc;
    logic [18:0] imm;
    logic        con_v;
    logic [31:0] exp_pc;
    logic        exp_taken;
  } br_vec_t;

  br_vec_t vecs[6];

  branch_pc_seq dut (
    .clk      (clk),
    .clr      (clr),
    .inc      (inc),
    .load     (load),
    .load_val (load_val),
    .br_start (br_start),
    .ir       (ir),
    .con      (con),
    .pc       (pc),
    .con_in   (con_in),
    .busy     (busy),
    .br_done  (br_done),
    .br_taken (br_taken)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Displacement as a plain signed integer taken from the 19-bit two's complement field
  function automatic logic [31:0] branch_target(input logic [31:0] base, input logic [18:0] imm);
    int d;
    d = imm[18] ? int'(imm) - (1 << 19) : int'(imm);
    return base + 32'(d);
  endfunction

  task automatic apply_idle(input logic i, input logic l, input logic [31:0] lv);
    inc = i; load = l; load_val = lv;
    step();
    inc = 1'b0; load = 1'b0;
    if (l)      m_pc = lv;
    else if (i) m_pc = m_pc + 1;
  endtask

  task automatic run_branch(input logic [18:0] imm, input logic con_v, input logic noise,
                            input logic inc0, input logic load0, input logic [31:0] lv0);
    logic [31:0] exp_pc;
    exp_pc = con_v ? branch_target(m_pc, imm) : m_pc;
    br_start = 1'b1; ir = {$urandom_range(8191, 0), imm}; inc = inc0; load = load0; load_val = lv0;
    step();
    br_start = 1'b0; ir = $urandom; con = ~con_v;
    inc = noise; load = noise; load_val = $urandom;
    check("strobe_con_in", 32'(con_in), 32'd1);
    check("strobe_busy", 32'(busy), 32'd1);
    check("strobe_pc", pc, m_pc);
    step();
    con = con_v;
    check("eval_con_in", 32'(con_in), 32'd0);
    check("eval_done", 32'(br_done), 32'd0);
    step();
    check("done_flag", 32'(br_done), 32'd1);
    check("done_taken", 32'(br_taken), 32'(con_v));
    check("done_pc", pc, exp_pc);
    check("done_busy", 32'(busy), 32'd1);
    step();
    inc = 1'b0; load = 1'b0; con = 1'b0;
    check("after_busy", 32'(busy), 32'd0);
    check("after_done", 32'(br_done), 32'd0);
    check("after_pc", pc, exp_pc);
    m_pc = exp_pc;
  endtask

  initial begin
    clr = 1'b1; inc = 0; load = 0; br_start = 0; con = 0; load_val = 0; ir = 0;
    vecs[0] = '{32'h10,       19'h00005, 1'b1, 32'h15,       1'b1};
    vecs[1] = '{32'h10,       19'h00005, 1'b0, 32'h10,       1'b0};
    vecs[2] = '{32'h3,        19'h7FFFC, 1'b1, 32'hFFFFFFFF, 1'b1};
    vecs[3] = '{32'hFFFFFFFE, 19'h00002, 1'b1, 32'h0,        1'b1};
    vecs[4] = '{32'h100,      19'h40000, 1'b1, 32'hFFFC0100, 1'b1};
    vecs[5] = '{32'h1234,     19'h3FFFF, 1'b0, 32'h1234,     1'b0};

    repeat (2) step();
    check("rst_pc", pc, 32'h0);
    check("rst_outs", {28'd0, con_in, busy, br_done, br_taken}, 32'd0);
    clr = 1'b0;
    m_pc = 0;

    // Reset in the middle of the strobe cycle
    repeat (5) apply_idle(1'b1, 1'b0, 32'h0);
    check("inc_to_5", pc, 32'h5);
    br_start = 1'b1; ir = 32'h5;
    step();
    br_start = 1'b0;
    #2 clr = 1'b1;
    #1;
    check("midrst_pc", pc, 32'h0);
    check("midrst_con_in", 32'(con_in), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    #2 clr = 1'b0;
    m_pc = 0;
    for (int c = 0; c < 4; c++) begin
      step();
      check("midrst_no_done", 32'(br_done), 32'd0);
    end
    check("midrst_pc_hold", pc, 32'h0);

    // Increment and wrap through load
    repeat (3) apply_idle(1'b1, 1'b0, 32'h0);
    check("inc_3", pc, 32'h3);
    apply_idle(1'b0, 1'b1, 32'hFFFFFFFF);
    check("load_ff", pc, 32'hFFFFFFFF);
    apply_idle(1'b1, 1'b0, 32'h0);
    check("inc_wrap", pc, 32'h0);
    apply_idle(1'b1, 1'b1, 32'hABCD0000);
    check("load_beats_inc", pc, 32'hABCD0000);

    for (int v = 0; v < 6; v++) begin
      apply_idle(1'b0, 1'b1, vecs[v].start_pc);
      run_branch(vecs[v].imm, vecs[v].con_v, v[0], 1'b0, 1'b0, 32'h0);
      check("vec_pc", pc, vecs[v].exp_pc);
      check("vec_model", m_pc, vecs[v].exp_pc);
    end

    // Branch wins over simultaneous load and inc; noise while busy is ignored
    apply_idle(1'b0, 1'b1, 32'h8);
    run_branch(19'h00003, 1'b1, 1'b1, 1'b1, 1'b1, 32'hDEADBEEF);
    check("arb_pc", pc, 32'hB);
    apply_idle(1'b0, 1'b1, 32'h8);
    run_branch(19'h00003, 1'b0, 1'b1, 1'b1, 1'b1, 32'hDEADBEEF);
    check("arb_nt_pc", pc, 32'h8);

    for (int r = 0; r < 200; r++) begin
      if ($urandom_range(3, 0) == 0)
        run_branch(19'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), $urandom);
      else begin
        apply_idle(1'($urandom), 1'($urandom), $urandom);
        check("rand_pc", pc, m_pc);
        check("rand_busy", 32'(busy), 32'd0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/branch_pc_seq.md
Name: branch_pc_seq

Overview:
Program-counter sequencer that consumes the CON flip-flop result for conditional branches (brzr/brnz/brpl/brmi).
- Owns the PC register and handles fetch increment and direct loads (jr/jal).
- On a branch it pulses the CON flip-flop's ConIn strobe, then samples the registered CON output one cycle later.
- If the condition holds, it adds the sign-extended 19-bit C field to PC.

Parameters:
- PC_W, 32, PC and load-value width.
- IMM_W, 19, branch displacement width (ir[18:0]).
- RESET_PC, 32'h0, PC value after reset.

Ports:
- clk  in  1  system clock, rising edge.
- clr  in  1  reset; asynchronous, active-high.
- inc  in  1  fetch increment request, PC <= PC+1.
- load  in  1  direct PC load request.
- load_val  in  PC_W  value for load.
- br_start  in  1  conditional-branch request; IR valid this cycle.
- ir  in  32  instruction register; only ir[18:0] is used.
- con  in  1  registered output of the CON flip-flop.
- pc  out  PC_W  current PC.
- con_in  out  1  ConIn strobe to the CON flip-flop.
- busy  out  1  branch sequence in progress.
- br_done  out  1  one-cycle pulse at branch completion.
- br_taken  out  1  branch outcome, valid while br_done=1.

Behaviour:

Reset (clr=1, async):
- pc=RESET_PC; state=IDLE.
- con_in=0, busy=0, br_done=0, br_taken=0; offset register=0.

States, registered, all outputs Moore: IDLE, STROBE, EVAL, DONE.

IDLE:
- One action per edge. Priority: br_start > load > inc.
- inc: pc <= pc+1, modulo 2^PC_W (32'hFFFFFFFF -> 0).
- load: pc <= load_val.
- br_start: off <= sign-extended ir[18:0] (ir[18] replicated to PC_W); state <= STROBE. The losing inc/load is dropped, not queued.

STROBE:
- con_in=1 and busy=1.
- At the next edge the external CON flip-flop captures its evaluation; state <= EVAL.
- con_in is high for exactly one cycle per branch.

EVAL:
- busy=1, con_in=0.
- At the edge, sample con.
- con=1: pc <= pc + off (modulo 2^PC_W) and taken <= 1.
- con=0: pc unchanged, taken <= 0.
- state <= DONE.

DONE:
- br_done=1, br_taken=taken, busy=1. The updated pc is visible in this same cycle.
- Next edge: state <= IDLE.

Timing and latency:
- br_start sampled at edge E0 -> con_in high between E0 and E1 -> con sampled at E2 -> br_done high between E2 and E3 -> IDLE after E3. Total 3 cycles.
- PC has already been incremented by fetch, so the target is PC+1+C.

While busy:
- inc, load and br_start are ignored and not queued.
- ir changes after E0 have no effect.

Outputs outside DONE:
- br_done=0 and br_taken=0.
- busy=0 only in IDLE.

Reset mid-sequence:
- Immediate return to IDLE with reset values.
- No br_done pulse and no PC update.
- If reset asserts during STROBE, con_in drops asynchronously.

Arithmetic:
- Unsigned PC_W-bit add; no overflow flag.
- A negative displacement wraps modulo 2^PC_W.

Decomposition:
- Shared package holds:
  - state encoding constants (IDLE=2'd0, STROBE=2'd1, EVAL=2'd2, DONE=2'd3);
  - IMM_W and the C-field bit positions (C_LSB=0, C_MSB=18);
  - the C2 field position (20:19), owned by the CON flip-flop and not decoded here.
- One natural sub-module: sext_imm (IMM_W -> PC_W sign extender, combinational).
- The PC and offset registers are inline.

Test Plan:
1. Reset: run inc to pc=5, assert clr mid-STROBE -> pc=0, con_in=0, busy=0 immediately; no br_done afterwards.
2. Increment: from reset, inc high 3 cycles -> pc=3. Then load=1, load_val=32'hFFFFFFFF, then inc -> pc=0 (wrap).
3. Taken branch: pc=32'h10, br_start with ir[18:0]=19'h00005, con=1 at EVAL -> con_in high exactly 1 cycle, br_done on third cycle after start, br_taken=1, pc=32'h15.
4. Not taken: pc=32'h10, same ir, con=0 -> br_done=1, br_taken=0, pc stays 32'h10.
5. Negative wrap: pc=32'h3, ir[18:0]=19'h7FFFC (-4), con=1 -> pc=32'hFFFFFFFF, br_taken=1.
6. Arbitration: in IDLE with pc=8, assert br_start+inc+load together -> branch wins and pc is not 9 or load_val. inc/load pulses during STROBE/EVAL/DONE -> pc changes only by the branch offset.
